// File: rtl/regfile_writeback_queue.sv
// In-order write-back FIFO between the ALU/load producers and the register-file
// write port; retires one write per cycle and flags pending writes for hazard checks.
module regfile_writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_WIDTH-1:0]   alu_addr,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    hold,
    output logic                    w_enable,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic [DATA_WIDTH-1:0]   data_in,
    input  logic [ADDR_WIDTH-1:0]   chk_addr1,
    input  logic [ADDR_WIDTH-1:0]   chk_addr2,
    output logic                    pending1,
    output logic                    pending2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic                  w_enable_r;
    logic [ADDR_WIDTH-1:0] data_addr_r;
    logic [DATA_WIDTH-1:0] data_in_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  alu_ready_s;
    logic                  mem_ready_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] push_addr_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic                  pending1_s;
    logic                  pending2_s;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign mem_ready_s = !full_s;
    assign alu_ready_s = !full_s && !mem_valid;

    // Source select with load priority; x0 destinations complete the handshake but are dropped
    always_comb begin
        if (mem_valid) begin
            push_addr_s = mem_addr;
            push_data_s = mem_data;
        end else begin
            push_addr_s = alu_addr;
            push_data_s = alu_data;
        end
        accept_s = (mem_valid && mem_ready_s) || (alu_valid && alu_ready_s);
        push_s   = accept_s && (push_addr_s != {ADDR_WIDTH{1'b0}});
        pop_s    = !empty_s && !hold;
    end

    // Hazard lookup: any valid queued entry or the write currently on the port
    always_comb begin
        pending1_s = 1'b0;
        pending2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending1_s = pending1_s | (valid_r[i] && (addr_mem_r[i] == chk_addr1));
            pending2_s = pending2_s | (valid_r[i] && (addr_mem_r[i] == chk_addr2));
        end
        pending1_s = (chk_addr1 != {ADDR_WIDTH{1'b0}}) &&
                     (pending1_s || (w_enable_r && (data_addr_r == chk_addr1)));
        pending2_s = (chk_addr2 != {ADDR_WIDTH{1'b0}}) &&
                     (pending2_s || (w_enable_r && (data_addr_r == chk_addr2)));
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= push_addr_s;
                data_mem_r[tail_r] <= push_data_s;
                valid_r[tail_r]    <= 1'b1;
                tail_r             <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file write port; address/data hold their last value when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_enable_r  <= 1'b0;
            data_addr_r <= {ADDR_WIDTH{1'b0}};
            data_in_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            w_enable_r <= pop_s;
            if (pop_s) begin
                data_addr_r <= addr_mem_r[head_r];
                data_in_r   <= data_mem_r[head_r];
            end
        end
    end

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign w_enable  = w_enable_r;
    assign data_addr = data_addr_r;
    assign data_in   = data_in_r;
    assign pending1  = pending1_s;
    assign pending2  = pending2_s;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scenario bench for regfile_writeback_queue: expected writes are queued at stimulus
// time and matched against writes observed on the register-file port.
module tb_regfile_writeback_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, hold;
    logic [4:0]  alu_addr, mem_addr, data_addr, chk_addr1, chk_addr2;
    logic [31:0] alu_data, mem_data, data_in;
    logic        w_enable, pending1, pending2, full, empty;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .hold(hold), .w_enable(w_enable), .data_addr(data_addr), .data_in(data_in),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .pending1(pending1), .pending2(pending2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write the DUT issues, tagged with its cycle
    always @(negedge clk) begin
        if (w_enable === 1'b1) obs_q.push_back('{data_addr, data_in, cyc});
    end

    task automatic drain(input string name);
        wr_t e, o;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.addr !== e.addr || o.data !== e.data || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                n_err++;
                $display("FAIL %s_write: got r%0d=%h @%0d, want r%0d=%h @%0d",
                         name, o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_leftover: got exp=%0d obs=%0d, want 0/0", name, exp_q.size(), obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        n_cmp++; if (w_enable !== 1'b0 || data_addr !== 5'd0 || data_in !== 32'd0) begin
            n_err++; $display("FAIL reset_port: got we=%b addr=%0d data=%h want 0/0/0", w_enable, data_addr, data_in); end
        n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got mem=%b alu=%b want 1/1", mem_ready, alu_ready); end
        reset = 1'b1;
        obs_q.delete();
    endtask

    task automatic test_single_alu();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'hFFFF_FFFF;
        exp_q.push_back('{5'd4, 32'hFFFF_FFFF, cyc + 2});
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        @(negedge clk);
        alu_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (count !== 3'd0 || w_enable !== 1'b0) begin n_err++; $display("FAIL single_idle: got count=%0d we=%b want 0/0", count, w_enable); end
        drain("single");
    endtask

    task automatic test_x0_drop();
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234_5678;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", alu_ready); end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL x0_count: got count=%0d empty=%b want 0/1", count, empty); end
        repeat (4) @(negedge clk);
        drain("x0");
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hAAAA_0000;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h5555_0000;
        exp_q.push_back('{5'd3, 32'hAAAA_0000, cyc + 2});
        exp_q.push_back('{5'd5, 32'h5555_0000, cyc + 3});
        #1;
        n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin n_err++; $display("FAIL arb_ready: got mem=%b alu=%b want 1/0", mem_ready, alu_ready); end
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL arb_alu_next: got %b want 1", alu_ready); end
        @(negedge clk);
        alu_valid = 1'b0;
        repeat (4) @(negedge clk);
        drain("arb");
    endtask

    task automatic test_full_hold();
        int r;
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'(i);
            #1;
            n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL full_push%0d_ready: got %b want 1", i, alu_ready); end
        end
        @(negedge clk);
        alu_addr = 5'd5; alu_data = 32'd5;
        #1;
        n_cmp++; if (full !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL full_flag: got full=%b count=%0d want 1/4", full, count); end
        n_cmp++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got mem=%b alu=%b want 0/0", mem_ready, alu_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (count !== 3'd4 || w_enable !== 1'b0) begin n_err++; $display("FAIL full_held: got count=%0d we=%b want 4/0", count, w_enable); end
        @(negedge clk);
        hold = 1'b0;
        r = cyc;
        for (int i = 1; i <= 4; i++) exp_q.push_back('{5'(i), 32'(i), r + i});
        exp_q.push_back('{5'd5, 32'd5, r + 5});
        #1;
        n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL full_release_ready: got %b want 0", alu_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (alu_ready !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL full_drop_ready: got alu=%b full=%b want 1/0", alu_ready, full); end
        @(negedge clk);
        alu_valid = 1'b0;
        repeat (6) @(negedge clk);
        drain("full");
    endtask

    task automatic test_pending();
        int r;
        hold = 1'b1; chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_0077;
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_cmp++; if (pending1 !== 1'b1 || pending2 !== 1'b0) begin n_err++; $display("FAIL pend_queued: got p1=%b p2=%b want 1/0", pending1, pending2); end
        @(negedge clk);
        hold = 1'b0;
        r = cyc;
        exp_q.push_back('{5'd7, 32'h0000_0077, r + 1});
        @(negedge clk);
        #1;
        n_cmp++; if (pending1 !== 1'b1 || w_enable !== 1'b1) begin n_err++; $display("FAIL pend_write: got p1=%b we=%b want 1/1", pending1, w_enable); end
        @(negedge clk);
        #1;
        n_cmp++; if (pending1 !== 1'b0 || w_enable !== 1'b0) begin n_err++; $display("FAIL pend_clear: got p1=%b we=%b want 0/0", pending1, w_enable); end
        chk_addr1 = 5'd0;
        drain("pend");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d = $urandom;
            mem_valid = 1'b1; mem_addr = 5'(20 + i); mem_data = d;
            exp_q.push_back('{5'(20 + i), d, cyc + 2});
            #1;
            n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, mem_ready); end
            if (i > 0) begin
                n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
            end
        end
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (4) @(negedge clk);
        drain("b2b");
    endtask

    task automatic test_reset_midop();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_valid = 1'b1; mem_addr = 5'(10 + i); mem_data = 32'(100 + i);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL midrst_fill: got %0d want 3", count); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; hold = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || w_enable !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: got count=%0d empty=%b we=%b want 0/1/0", count, empty, w_enable); end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_after: got %0d want 0", count); end
        drain("midrst");
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_x0_drop();
        test_arbitration();
        test_full_hold();
        test_pending();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
